serial_add_ctrl: RTL

SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

---
 rtl/serial_add_ctrl.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/serial_add_ctrl.sv
// -----------------------------------------------------------------------------
// serial_add_ctrl
//
// Bit-serial adder. A single full-add stage, with its carry fed back through a
// flop, is sequenced LSB-first over WIDTH clock cycles. On an accepted start,
// the operands are captured into shift registers. Each RUN cycle consumes one
// bit of each operand and shifts one result bit into the top of the sum
// register. After WIDTH cycles the full result sits in sum and the final carry
// sits in cout.
//
// Ports
//   clk    in   1      single clock; all state updates on the rising edge
//   rst_n  in   1      asynchronous active-low reset
//   start  in   1      add request, sampled only in IDLE
//   a_in   in   WIDTH  operand A, captured on the accepting edge
//   b_in   in   WIDTH  operand B, captured on the accepting edge
//   sum    out  WIDTH  (A+B) mod 2^WIDTH; valid from done, held until next start
//   cout   out  1      carry-out of bit WIDTH-1
//   busy   out  1      high exactly while in RUN
//   done   out  1      one-cycle pulse (state DONE) marking sum/cout valid
//
// Timing: start accepted at edge k -> done high in the cycle after edge
// k+WIDTH. Back-to-back throughput is one addition every WIDTH+2 cycles.
// -----------------------------------------------------------------------------
module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy,
    output logic             done
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    // Each output owns one state bit: busy = bit 0 and done = bit 1. A flop
    // output never glitches, including on the RUN->DONE step where both
    // bits change together.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t           state;
    state_t           state_next;

    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] sum_r;
    logic             carry;
    logic             cout_r;
    logic [CNT_W-1:0] bit_cnt;

    logic             s_bit;
    logic             c_next;
    logic             last_bit;

    // One full-add stage acting on the current LSBs and the fed-back carry.
    assign s_bit    = a_sh[0] ^ b_sh[0] ^ carry;
    assign c_next   = (a_sh[0] & b_sh[0]) | (a_sh[0] & carry) | (b_sh[0] & carry);
    assign last_bit = (bit_cnt == LAST_BIT);

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    // NOTE: sequential state always uses non-blocking assignments. Every flop
    // then samples its pre-edge value, whatever order the processes run in.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    // NOTE: the default assignment at the top keeps this block combinational.
    // Without it, any path that skipped state_next would infer a latch.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (last_bit) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // Output decode (registered state bits only)
    // -------------------------------------------------------------------------
    always_comb begin
        busy = state[0];
        done = state[1];
    end

    // -------------------------------------------------------------------------
    // Datapath
    // -------------------------------------------------------------------------
    // NOTE: every datapath register is cleared by reset, not only the control
    // state. An aborted addition must leave no stale sum, carry or operand.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh    <= '0;
            b_sh    <= '0;
            sum_r   <= '0;
            carry   <= 1'b0;
            cout_r  <= 1'b0;
            bit_cnt <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    // sum_r and cout_r hold the previous result until a start
                    // is accepted. WIDTH shifts then fully overwrite sum_r.
                    if (start) begin
                        a_sh    <= a_in;
                        b_sh    <= b_in;
                        carry   <= 1'b0;
                        bit_cnt <= '0;
                    end
                end
                RUN: begin
                    a_sh    <= a_sh >> 1;
                    b_sh    <= b_sh >> 1;
                    sum_r   <= {s_bit, sum_r[WIDTH-1:1]};
                    carry   <= c_next;
                    bit_cnt <= bit_cnt + CNT_W'(1);
                    if (last_bit) begin
                        cout_r <= c_next;
                    end
                end
                default: ;
            endcase
        end
    end

    assign sum  = sum_r;
    assign cout = cout_r;

endmodule
